// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
//
// Instruction prefetcher sitting between a core fetch stage and an in-order,
// pipelined memory port. Fetches sequential words ahead of the core into a
// small FIFO and flushes and redirects on a branch.
//
// Parameters
//   DEPTH      FIFO entries; also the cap on buffered + in-flight fetches (2..8)
//   BOOT_ADDR  first fetch address after reset
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_i                              core allows new fetches
//   branch_i, branch_addr_i            flush buffer and redirect fetch
//   valid_o, ready_i                   head-of-FIFO handshake to the core
//   rdata_o, addr_o, err_o             head word, its address, its bus error
//   instr_req_o, instr_addr_o,
//   instr_gnt_i                        memory request/grant
//   instr_rvalid_i, instr_rdata_i,
//   instr_err_i                        memory response (in order, one per grant)
//
// Build option
//   IPF_ERR_TRAP_EN  when defined, bus errors are stored per entry, err_o shows
//                    the head's error, and fetching halts once an error entry is
//                    buffered until the next branch. When undefined, err_o is 0
//                    and instr_err_i is ignored.

module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic {StIdle, StWaitGnt} state_e;

  state_e            r_state;
  logic [31:0]       r_faddr;     // next address to request
  logic              r_bpend;     // branch seen while a request awaits grant
  logic [31:0]       r_baddr;     // target to load once that request is granted
  logic [31:0]       r_raddr;     // address belonging to the next kept response
  logic [CntW-1:0]   r_outst;     // granted, response not yet returned
  logic [CntW-1:0]   r_discard;   // responses still to be dropped
  logic [CntW-1:0]   r_count;
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [31:0]       r_fifo_data [DEPTH];
  logic [31:0]       r_fifo_addr [DEPTH];

  logic              w_gnt;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_stop_n;
  logic              w_start;
  logic [31:0]       w_tgt;
  logic [CntW-1:0]   w_outst_n;
  logic [CntW-1:0]   w_discard_n;
  logic [CntW-1:0]   w_count_n;
  logic              w_unused;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_tgt   = {branch_addr_i[31:2], 2'b00};
  assign w_gnt   = (r_state == StWaitGnt) & instr_gnt_i;
  assign w_drop  = (r_discard != '0);
  assign w_valid = (r_count != '0);
  // A branch wins over any push or pop in the same cycle.
  assign w_push  = instr_rvalid_i & ~w_drop & ~branch_i;
  assign w_pop   = w_valid & ready_i & ~branch_i;

`ifdef IPF_ERR_TRAP_EN
  logic             r_stop;
  logic [DEPTH-1:0] r_fifo_err;

  assign w_stop_n = branch_i ? 1'b0 : (r_stop | (w_push & instr_err_i));
  assign err_o    = w_valid & r_fifo_err[r_rptr];
  assign w_unused = ^branch_addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stop <= 1'b0;
    end else begin
      r_stop <= w_stop_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_err[r_wptr] <= instr_err_i;
    end
  end
`else
  assign w_stop_n = 1'b0;
  assign err_o    = 1'b0;
  assign w_unused = ^{branch_addr_i[1:0], instr_err_i};
`endif

  always_comb begin
    w_outst_n = r_outst;
    if (w_gnt) begin
      w_outst_n = w_outst_n + CntOne;
    end
    if (instr_rvalid_i) begin
      w_outst_n = w_outst_n - CntOne;
    end

    w_discard_n = r_discard;
    if (instr_rvalid_i && w_drop) begin
      w_discard_n = w_discard_n - CntOne;
    end
    // The request that was pending at branch time is now in flight; drop it too.
    if (w_gnt && r_bpend) begin
      w_discard_n = w_discard_n + CntOne;
    end
    if (branch_i) begin
      w_discard_n = w_outst_n;
    end

    w_count_n = r_count;
    if (branch_i) begin
      w_count_n = '0;
    end else begin
      if (w_push) begin
        w_count_n = w_count_n + CntOne;
      end
      if (w_pop) begin
        w_count_n = w_count_n - CntOne;
      end
    end
  end

  // Credit is judged on next-cycle occupancy so a slot freed this cycle is reused
  // immediately, while buffered + in-flight never exceeds DEPTH.
  assign w_start = req_i & ~w_stop_n & ((32'(w_count_n) + 32'(w_outst_n)) < DEPTH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_faddr   <= BOOT_ADDR;
      r_bpend   <= 1'b0;
      r_baddr   <= BOOT_ADDR;
      r_raddr   <= BOOT_ADDR;
      r_outst   <= '0;
      r_discard <= '0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      r_outst   <= w_outst_n;
      r_discard <= w_discard_n;
      r_count   <= w_count_n;

      if (branch_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_raddr <= w_tgt;
      end else begin
        if (w_push) begin
          r_wptr  <= ptr_inc(r_wptr);
          r_raddr <= r_raddr + 32'd4;
        end
        if (w_pop) begin
          r_rptr <= ptr_inc(r_rptr);
        end
      end

      // An ungranted request keeps its address; a redirect lands after the grant.
      if (w_gnt) begin
        r_bpend <= 1'b0;
        if (branch_i) begin
          r_faddr <= w_tgt;
        end else if (r_bpend) begin
          r_faddr <= r_baddr;
        end else begin
          r_faddr <= r_faddr + 32'd4;
        end
      end else if (branch_i) begin
        if (r_state == StWaitGnt) begin
          r_bpend <= 1'b1;
          r_baddr <= w_tgt;
        end else begin
          r_faddr <= w_tgt;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= StWaitGnt;
          end
        end
        StWaitGnt: begin
          if (w_gnt && !w_start) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= instr_rdata_i;
      r_fifo_addr[r_wptr] <= r_raddr;
    end
  end

  assign instr_req_o  = (r_state == StWaitGnt);
  assign instr_addr_o = r_faddr;
  assign valid_o      = w_valid;
  assign rdata_o      = w_valid ? r_fifo_data[r_rptr] : '0;
  assign addr_o       = w_valid ? r_fifo_addr[r_rptr] : '0;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH=4, BOOT_ADDR=0x80).
// A negedge-driven memory model grants per instr_gnt_i and answers one cycle
// after each grant with rdata = addr ^ 32'hDEAD_BEEF.

module tb_instr_prefetch_buffer;

  localparam logic [31:0] DKey = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rsp_en = 1'b1;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] rsp_q[$];
  logic [31:0] gnt_log[$];

  instr_prefetch_buffer #(
    .DEPTH    (4),
    .BOOT_ADDR(32'h0000_0080)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .err_o         (err_o),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .instr_err_i   (instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: answer earlier grants first, then record the grant that the
  // coming rising edge will take, so each response lands one cycle after it.
  always @(negedge clk_i) begin
    if (rsp_en && rsp_q.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rsp_q[0] ^ DKey;
      instr_err_i    = (rsp_q[0] == err_addr);
      void'(rsp_q.pop_front());
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
    end
    if (rst_ni && instr_req_o && instr_gnt_i) begin
      rsp_q.push_back(instr_addr_o);
      gnt_log.push_back(instr_addr_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Wait (bounded) for the next head entry and check it; ready_i must be 1.
  task automatic expect_pop(input string tag, input logic [31:0] a, input logic e);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: valid_o never rose, observed=0 expected=1", tag);
    end else begin
      chk({tag, "/addr"}, addr_o, a);
      chk({tag, "/rdata"}, rdata_o, a ^ DKey);
      chk({tag, "/err"}, 32'(err_o), 32'(e));
    end
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    req_i         = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = '0;
    ready_i       = 1'b0;
    instr_gnt_i   = 1'b0;
    rsp_en        = 1'b1;
    err_addr      = 32'h1;
    step(2);
    chk("rst/instr_req", 32'(instr_req_o), 32'd0);
    chk("rst/instr_addr", instr_addr_o, 32'h80);
    chk("rst/valid", 32'(valid_o), 32'd0);
    chk("rst/rdata", rdata_o, 32'd0);
    chk("rst/addr", addr_o, 32'd0);
    chk("rst/err", 32'(err_o), 32'd0);
    rsp_q.delete();
    gnt_log.delete();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Sequential fetch from BOOT_ADDR with a free-flowing bus and core.
    do_reset();
    instr_gnt_i = 1'b1;
    ready_i     = 1'b1;
    req_i       = 1'b1;
    expect_pop("seq0", 32'h80, 1'b0);
    expect_pop("seq1", 32'h84, 1'b0);
    expect_pop("seq2", 32'h88, 1'b0);
    expect_pop("seq3", 32'h8C, 1'b0);
    step(1);
    chk("seq/gnt0", log_at(0), 32'h80);
    chk("seq/gnt1", log_at(1), 32'h84);
    chk("seq/gnt2", log_at(2), 32'h88);
    chk("seq/gnt3", log_at(3), 32'h8C);

    // Core stalled: credit caps issue at DEPTH, one pop frees one request.
    do_reset();
    instr_gnt_i = 1'b1;
    req_i       = 1'b1;
    step(15);
    chk("stall/ngnt", 32'(gnt_log.size()), 32'd4);
    chk("stall/req", 32'(instr_req_o), 32'd0);
    chk("stall/valid", 32'(valid_o), 32'd1);
    chk("stall/head", addr_o, 32'h80);
    ready_i = 1'b1;
    step(1);
    ready_i = 1'b0;
    step(10);
    chk("stall/ngnt_after_pop", 32'(gnt_log.size()), 32'd5);
    chk("stall/gnt4", log_at(4), 32'h90);
    chk("stall/req_after_pop", 32'(instr_req_o), 32'd0);
    chk("stall/head_after_pop", addr_o, 32'h84);

    // Asynchronous reset with a full buffer: outputs clear before any clock edge.
    rst_ni = 1'b0;
    #1;
    chk("async/valid", 32'(valid_o), 32'd0);
    chk("async/addr", addr_o, 32'd0);
    chk("async/instr_addr", instr_addr_o, 32'h80);

    // Grant held off at 0x84 while a branch to 0x201 arrives.
    do_reset();
    ready_i = 1'b1;
    req_i   = 1'b1;
    for (int i = 0; i < 10 && instr_req_o !== 1'b1; i++) step(1);
    chk("hold/first_addr", instr_addr_o, 32'h80);
    instr_gnt_i = 1'b1;
    step(1);
    instr_gnt_i   = 1'b0;
    branch_i      = 1'b1;
    branch_addr_i = 32'h201;
    chk("hold/addr_c0", instr_addr_o, 32'h84);
    step(1);
    branch_i = 1'b0;
    chk("hold/req_c1", 32'(instr_req_o), 32'd1);
    chk("hold/addr_c1", instr_addr_o, 32'h84);
    step(1);
    chk("hold/req_c2", 32'(instr_req_o), 32'd1);
    chk("hold/addr_c2", instr_addr_o, 32'h84);
    instr_gnt_i = 1'b1;
    expect_pop("hold/first_valid", 32'h200, 1'b0);
    chk("hold/gnt1", log_at(1), 32'h84);
    chk("hold/gnt2", log_at(2), 32'h200);

    // Branch coinciding with pop and rvalid, leaving two responses in flight.
    do_reset();
    instr_gnt_i = 1'b1;
    req_i       = 1'b1;
    rsp_en      = 1'b0;
    step(10);
    chk("flush/ngnt", 32'(gnt_log.size()), 32'd4);
    chk("flush/empty", 32'(valid_o), 32'd0);
    rsp_en = 1'b1;
    step(1);
    rsp_en = 1'b0;
    step(3);
    chk("flush/one_buffered", 32'(valid_o), 32'd1);
    chk("flush/head", addr_o, 32'h80);
    ready_i       = 1'b1;
    rsp_en        = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h300;
    step(1);
    branch_i = 1'b0;
    chk("flush/valid_after_branch", 32'(valid_o), 32'd0);
    expect_pop("flush/first_valid", 32'h300, 1'b0);
    chk("flush/gnt4", log_at(4), 32'h300);

    // Address wrap at the top of the address space.
    do_reset();
    instr_gnt_i   = 1'b1;
    ready_i       = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFFE;
    step(1);
    branch_i = 1'b0;
    req_i    = 1'b1;
    expect_pop("wrap/top", 32'hFFFF_FFFC, 1'b0);
    expect_pop("wrap/zero", 32'h0, 1'b0);
    step(1);
    chk("wrap/gnt0", log_at(0), 32'hFFFF_FFFC);
    chk("wrap/gnt1", log_at(1), 32'h0);

    // Bus error on 0x88.
    do_reset();
    err_addr    = 32'h88;
    instr_gnt_i = 1'b1;
    ready_i     = 1'b1;
    req_i       = 1'b1;
    expect_pop("err/e80", 32'h80, 1'b0);
    expect_pop("err/e84", 32'h84, 1'b0);
`ifdef IPF_ERR_TRAP_EN
    expect_pop("err/e88", 32'h88, 1'b1);
    expect_pop("err/e8c", 32'h8C, 1'b0);
    step(10);
    chk("err/halted_req", 32'(instr_req_o), 32'd0);
    chk("err/halted_ngnt", 32'(gnt_log.size()), 32'd4);
    branch_i      = 1'b1;
    branch_addr_i = 32'h400;
    step(1);
    branch_i = 1'b0;
    expect_pop("err/resume", 32'h400, 1'b0);
`else
    expect_pop("err/e88", 32'h88, 1'b0);
    expect_pop("err/e8c", 32'h8C, 1'b0);
    expect_pop("err/e90", 32'h90, 1'b0);
`endif

    step(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries and max in-flight-plus-buffered fetches (2..8).
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0080, fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  core enables fetching.
REQ-006 SHALL have port branch_i  input  1  redirect fetch, flush buffer.
REQ-007 SHALL have port branch_addr_i  input  32  redirect target.
REQ-008 SHALL have port valid_o  output  1  head entry available to core.
REQ-009 SHALL have port ready_i  input  1  core consumes head entry.
REQ-010 SHALL have port rdata_o  output  32  head instruction word.
REQ-011 SHALL have port addr_o  output  32  head instruction address.
REQ-012 SHALL have port err_o  output  1  head entry fetched with bus error.
REQ-013 SHALL have ports instr_req_o out 1, instr_addr_o out 32, instr_gnt_i in 1, instr_rvalid_i in 1, instr_rdata_i in 32, instr_err_i in 1: memory fetch handshake.

Function
REQ-014 SHALL keep fetch address faddr, word-aligned ({addr[31:2],2'b00}); branch_addr_i bits [1:0] ignored.
REQ-015 SHALL use FSM IDLE/WAIT_GNT: IDLE->WAIT_GNT when req_i and credit available (buffered + outstanding < DEPTH); instr_req_o=1 in WAIT_GNT only, instr_addr_o=faddr.
REQ-016 SHALL, in WAIT_GNT, hold instr_req_o and instr_addr_o stable until instr_gnt_i; a request is never retracted, even on branch_i or req_i deassertion.
REQ-017 SHALL on grant increment outstanding count and faddr by 4 (wraps 32'hFFFF_FFFC -> 0); back-to-back request next cycle only if credit remains, else IDLE.
REQ-018 SHALL decrement outstanding on instr_rvalid_i; responses return in order, one per grant.
REQ-019 SHALL push {instr_rdata_i, address, instr_err_i} on rvalid when discard count is 0; entry visible on valid_o the following cycle (1-cycle latency).
REQ-020 SHALL drive valid_o = FIFO non-empty; rdata_o/addr_o/err_o from head; pop on valid_o & ready_i.
REQ-021 SHALL never overflow: credit rule guarantees space; push and pop in same cycle both take effect.
REQ-022 SHALL on branch_i: clear FIFO, set discard count = outstanding after this cycle's grant/rvalid, load faddr = branch_addr_i (if WAIT_GNT ungranted, load faddr after that grant).
REQ-023 SHALL drop responses while discard count > 0, decrementing per rvalid.
REQ-024 SHALL give branch_i priority over simultaneous pop and push; valid_o = 0 the cycle after branch.
REQ-025 SHALL issue no new request while req_i=0; outstanding responses still complete.

Reset
REQ-026 SHALL on rst_ni low asynchronously force IDLE, faddr=BOOT_ADDR, FIFO empty, outstanding=0, discard=0.
REQ-027 SHALL drive during reset: instr_req_o=0, instr_addr_o=BOOT_ADDR, valid_o=0, rdata_o=0, addr_o=0, err_o=0.
REQ-028 SHALL on reset mid-transaction abandon all in-flight state; post-reset responses are not expected by environment.

Configuration
REQ-029 SHALL support macro IPF_ERR_TRAP_EN.
REQ-030 SHALL with IPF_ERR_TRAP_EN defined: store instr_err_i per entry, err_o reflects head, and stop issuing requests after an error response is buffered until next branch_i.
REQ-031 SHALL without IPF_ERR_TRAP_EN: err_o tied 0, instr_err_i ignored, prefetch continues.

Verification
REQ-032 Reset release, req_i=1, gnt always 1, rvalid 1 cycle later -> addresses 0x80,0x84,0x88,0x8C issued; valid_o data in order, addr_o 0x80 first.
REQ-033 ready_i=0, DEPTH=4 -> exactly 4 grants then instr_req_o=0; one pop -> exactly one new request.
REQ-034 gnt delayed 3 cycles at 0x84 with branch_i to 0x201 meanwhile -> 0x84 held until grant, response dropped, next request 0x200, first valid addr_o 0x200.
REQ-035 branch_i same cycle as pop and rvalid with 2 outstanding -> FIFO empty next cycle, next 2 responses dropped.
REQ-036 IPF_ERR_TRAP_EN, instr_err_i=1 on 0x88 -> err_o=1 with addr_o 0x88, no further requests until branch_i; macro off -> err_o=0, fetching continues.
REQ-037 faddr 32'hFFFF_FFFC granted -> next request address 32'h0000_0000.
